booth_seq_multiplier: RTL and testbench

Sequential signed multiplier: radix-4 Booth, one recoded digit pair per clock. It is the MUL counterpart to the combinational divider in the ALU. It drives the 64-bit HI/LO result pair for the CPU datapath. A start/busy/done handshake lets the control unit stall while the product forms.

---
 rtl/mul_pkg.sv | 24 ++
 rtl/booth_r4_encoder.sv | 18 +
 rtl/booth_seq_multiplier.sv | 178 +++++++++++++++++
 tb/tb_booth_seq_multiplier.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared types and constants for the sequential radix-4 Booth multiplier.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_t;

  // One recoded radix-4 digit: magnitude is one or two, neg flips the sign.
  typedef struct packed {
    logic neg;
    logic one;
    logic two;
  } booth_ctrl_t;

  localparam int MUL_WIDTH = 32;
  localparam int MUL_ITERS = MUL_WIDTH / 2;

  function automatic int mul_iters(input int width);
    return width / 2;
  endfunction

endpackage

// File: rtl/booth_r4_encoder.sv
// Radix-4 Booth recoder: three overlapping multiplier bits to a signed digit
// in {-2,-1,0,+1,+2}, expressed as neg/one/two controls.
module booth_r4_encoder
  import mul_pkg::*;
(
  input  logic [2:0]  bits_i,
  output booth_ctrl_t ctrl_o
);

  always_comb begin
    ctrl_o.one = bits_i[1] ^ bits_i[0];
    ctrl_o.two = (bits_i[2] & ~bits_i[1] & ~bits_i[0]) |
                 (~bits_i[2] & bits_i[1] & bits_i[0]);
    // 3'b111 is a zero digit, so it must not assert neg.
    ctrl_o.neg = bits_i[2] & ~(bits_i[1] & bits_i[0]);
  end

endmodule

// File: rtl/booth_seq_multiplier.sv
// Sequential radix-4 Booth multiplier, one digit per clock, registered HI/LO.
// Optional unsigned mode (is_unsigned port) is built when MUL_UNSIGNED_EN is defined.
module booth_seq_multiplier
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
`ifdef MUL_UNSIGNED_EN
  input  logic             is_unsigned,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int ITERS = mul_iters(WIDTH);
  localparam int AW    = WIDTH + 2;
`ifdef MUL_UNSIGNED_EN
  localparam int QW    = WIDTH + 2;
`else
  localparam int QW    = WIDTH;
`endif
  localparam int CW    = $clog2(ITERS + 2);
  localparam logic [CW-1:0] LAST_S = CW'(ITERS - 1);
`ifdef MUL_UNSIGNED_EN
  localparam logic [CW-1:0] LAST_U = CW'(ITERS);
`endif

  mul_state_t      state_q;
  logic            busy_q, done_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic [AW-1:0]   m_q, acc_q;
  logic [QW-1:0]   q_q;
  logic            qm1_q;
  logic [CW-1:0]   cnt_q;
`ifdef MUL_UNSIGNED_EN
  logic            unsigned_q;
`endif

  logic [AW-1:0]   m_ext;
  logic [QW-1:0]   q_ext;
  logic [CW-1:0]   last_iter;
  booth_ctrl_t     ctrl;
  logic [AW-1:0]   base, pp, sum;
  logic [AW-1:0]   acc_d;
  logic [QW-1:0]   q_d;
  logic            qm1_d;
  logic [WIDTH-1:0] hi_d, lo_d;
  logic            load;

  // Operand extension at capture: two guard bits keep 2*M exact for M = -2^(WIDTH-1).
  always_comb begin
`ifdef MUL_UNSIGNED_EN
    if (is_unsigned) begin
      m_ext = {2'b00, multiplicand};
      q_ext = {2'b00, multiplier};
    end else begin
      m_ext = {{2{multiplicand[WIDTH-1]}}, multiplicand};
      q_ext = {{2{multiplier[WIDTH-1]}}, multiplier};
    end
    last_iter = unsigned_q ? LAST_U : LAST_S;
`else
    m_ext     = {{2{multiplicand[WIDTH-1]}}, multiplicand};
    q_ext     = multiplier;
    last_iter = LAST_S;
`endif
  end

  booth_r4_encoder u_enc (
    .bits_i ({q_q[1], q_q[0], qm1_q}),
    .ctrl_o (ctrl)
  );

  always_comb begin
    base = '0;
    if (ctrl.two) begin
      base = {m_q[AW-2:0], 1'b0};
    end else if (ctrl.one) begin
      base = m_q;
    end
    pp    = ctrl.neg ? (~base + AW'(1)) : base;
    sum   = acc_q + pp;
    acc_d = {sum[AW-1], sum[AW-1], sum[AW-1:2]};
    q_d   = {sum[1:0], q_q[QW-1:2]};
    qm1_d = q_q[1];
    hi_d  = acc_d[WIDTH-1:0];
    lo_d  = q_d[QW-1 -: WIDTH];
`ifdef MUL_UNSIGNED_EN
    // The extra unsigned iteration shifts the product two bits further down.
    if (unsigned_q) begin
      hi_d = {acc_d[WIDTH-3:0], q_d[QW-1 -: 2]};
      lo_d = q_d[WIDTH-1:0];
    end
`endif
  end

  // Handshake: start is accepted on a rising edge only in IDLE or DONE; busy is
  // high for every RUN cycle and done pulses for one cycle with hi/lo valid.
  assign load = start && (state_q == IDLE || state_q == DONE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      m_q        <= '0;
      acc_q      <= '0;
      q_q        <= '0;
      qm1_q      <= 1'b0;
      cnt_q      <= '0;
`ifdef MUL_UNSIGNED_EN
      unsigned_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
          end
        end
        RUN: begin
          acc_q <= acc_d;
          q_q   <= q_d;
          qm1_q <= qm1_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == last_iter) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
          end else begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase

      if (load) begin
        m_q        <= m_ext;
        q_q        <= q_ext;
        qm1_q      <= 1'b0;
        acc_q      <= '0;
        cnt_q      <= '0;
`ifdef MUL_UNSIGNED_EN
        unsigned_q <= is_unsigned;
`endif
      end
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_booth_seq_multiplier.sv
// Directed self-checking bench for booth_seq_multiplier (WIDTH=32).
module tb_booth_seq_multiplier;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] multiplicand = '0;
  logic [W-1:0] multiplier = '0;
`ifdef MUL_UNSIGNED_EN
  logic         is_unsigned = 1'b0;
`endif
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int checks = 0;
  int failures = 0;

  localparam int NV = 9;
  localparam logic [W-1:0] VM [NV] = '{32'd7, 32'hFFFFFFFB, 32'hFFFFFFFF, 32'h80000000,
    32'h7FFFFFFF, 32'h80000000, 32'h00000000, 32'h12345678, 32'h00010003};
  localparam logic [W-1:0] VQ [NV] = '{32'd3, 32'd6, 32'hFFFFFFFF, 32'h80000000,
    32'h7FFFFFFF, 32'h7FFFFFFF, 32'h12345678, 32'hFFFFFFFE, 32'h00020005};
  localparam logic [W-1:0] VH [NV] = '{32'h0, 32'hFFFFFFFF, 32'h0, 32'h40000000,
    32'h3FFFFFFF, 32'hC0000000, 32'h0, 32'hFFFFFFFF, 32'h00000002};
  localparam logic [W-1:0] VL [NV] = '{32'h15, 32'hFFFFFFE2, 32'h1, 32'h0,
    32'h1, 32'h80000000, 32'h0, 32'hDB975310, 32'h000B000F};

  always #5 clock = ~clock;

  booth_seq_multiplier #(.WIDTH(W)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
`ifdef MUL_UNSIGNED_EN
    .is_unsigned  (is_unsigned),
`endif
    .busy         (busy),
    .done         (done),
    .hi           (hi),
    .lo           (lo)
  );

  task automatic start_op(input logic [W-1:0] m, input logic [W-1:0] q, input logic u);
    @(negedge clock);
    multiplicand = m;
    multiplier   = q;
`ifdef MUL_UNSIGNED_EN
    is_unsigned  = u;
`else
    if (u) $display("note: unsigned mode not built, running signed");
`endif
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
  endtask

  // Cycle 1 is the first cycle after the start edge; done_cyc=-1 on timeout.
  task automatic run_op(input logic do_start, input logic [W-1:0] m, input logic [W-1:0] q,
                        input logic u, input int inj_cyc, input logic [W-1:0] inj_m,
                        input logic [W-1:0] inj_q, output int done_cyc, output logic busy_ok,
                        output logic hold_ok, output logic [W-1:0] rhi, output logic [W-1:0] rlo);
    logic [W-1:0] hi0, lo0;
    done_cyc = -1;
    busy_ok  = 1'b1;
    hold_ok  = 1'b1;
    rhi      = 'x;
    rlo      = 'x;
    hi0      = hi;
    lo0      = lo;
    if (do_start) start_op(m, q, u);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clock);
      if (c == inj_cyc) begin
        multiplicand = inj_m;
        multiplier   = inj_q;
        start        = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        done_cyc = c;
        if (busy) busy_ok = 1'b0;
        rhi = hi;
        rlo = lo;
        break;
      end
      if (!busy) busy_ok = 1'b0;
      if (hi !== hi0 || lo !== lo0) hold_ok = 1'b0;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({busy, done} !== 2'b00 || hi !== '0 || lo !== '0) begin
      failures++;
      $display("FAIL reset_outputs: busy=%b done=%b hi=%h lo=%h, required all zero", busy, done, hi, lo);
    end
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    checks++;
    if ({busy, done} !== 2'b00 || hi !== '0 || lo !== '0) begin
      failures++;
      $display("FAIL reset_idle: busy=%b done=%b hi=%h lo=%h, required all zero", busy, done, hi, lo);
    end
  endtask

  task automatic test_signed();
    int dc;
    logic bok, hok;
    logic [W-1:0] rh, rl;
    for (int i = 0; i < NV; i++) begin
      run_op(1'b1, VM[i], VQ[i], 1'b0, 0, '0, '0, dc, bok, hok, rh, rl);
      checks++;
      if (dc !== 17) begin
        failures++;
        $display("FAIL signed_latency[%0d]: done at cycle %0d, required 17", i, dc);
      end
      checks++;
      if (bok !== 1'b1 || hok !== 1'b1) begin
        failures++;
        $display("FAIL signed_busy_hold[%0d]: busy_ok=%b hold_ok=%b, required 1 1", i, bok, hok);
      end
      checks++;
      if (rh !== VH[i] || rl !== VL[i]) begin
        failures++;
        $display("FAIL signed_product[%0d]: %h*%h gave %h_%h, required %h_%h",
                 i, VM[i], VQ[i], rh, rl, VH[i], VL[i]);
      end
      if (i == 0) begin
        @(negedge clock);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || hi !== VH[0] || lo !== VL[0]) begin
          failures++;
          $display("FAIL done_pulse: done=%b busy=%b hi=%h lo=%h after done, required 0 0 %h %h",
                   done, busy, hi, lo, VH[0], VL[0]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int dc1, dc2;
    logic bok, hok;
    logic [W-1:0] rh, rl;
    run_op(1'b1, 32'd7, 32'd3, 1'b0, 0, '0, '0, dc1, bok, hok, rh, rl);
    checks++;
    if (dc1 !== 17 || rh !== 32'h0 || rl !== 32'h15) begin
      failures++;
      $display("FAIL b2b_first: cycle %0d result %h_%h, required 17 00000000_00000015", dc1, rh, rl);
    end
    multiplicand = 32'h80000000;
    multiplier   = 32'd2;
    start        = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    run_op(1'b0, '0, '0, 1'b0, 0, '0, '0, dc2, bok, hok, rh, rl);
    checks++;
    if (dc2 !== 17 || bok !== 1'b1 || hok !== 1'b1) begin
      failures++;
      $display("FAIL b2b_timing: second done %0d cycles later busy_ok=%b hold_ok=%b, required 17 1 1",
               dc2, bok, hok);
    end
    checks++;
    if (rh !== 32'hFFFFFFFF || rl !== 32'h0) begin
      failures++;
      $display("FAIL b2b_second: result %h_%h, required ffffffff_00000000", rh, rl);
    end
  endtask

  task automatic test_ignore_start();
    int dc;
    logic bok, hok;
    logic [W-1:0] rh, rl;
    run_op(1'b1, 32'hFFFFFFFB, 32'd6, 1'b0, 5, 32'd9, 32'd9, dc, bok, hok, rh, rl);
    checks++;
    if (dc !== 17 || bok !== 1'b1) begin
      failures++;
      $display("FAIL ignore_latency: done at %0d busy_ok=%b, required 17 1", dc, bok);
    end
    checks++;
    if (rh !== 32'hFFFFFFFF || rl !== 32'hFFFFFFE2) begin
      failures++;
      $display("FAIL ignore_product: result %h_%h, required ffffffff_ffffffe2", rh, rl);
    end
    @(negedge clock);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL ignore_idle: busy=%b done=%b after done, required 0 0", busy, done);
    end
  endtask

  task automatic test_abort_reset();
    logic saw_done;
    start_op(32'd7, 32'd3, 1'b0);
    for (int c = 1; c <= 8; c++) @(negedge clock);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL abort_busy: busy=%b at cycle 8, required 1", busy);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({busy, done} !== 2'b00 || hi !== '0 || lo !== '0) begin
      failures++;
      $display("FAIL abort_clear: busy=%b done=%b hi=%h lo=%h, required all zero", busy, done, hi, lo);
    end
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    saw_done = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clock);
      if (done || busy) saw_done = 1'b1;
    end
    checks++;
    if (saw_done !== 1'b0 || hi !== '0 || lo !== '0) begin
      failures++;
      $display("FAIL abort_no_done: activity=%b hi=%h lo=%h, required 0 0 0", saw_done, hi, lo);
    end
  endtask

`ifdef MUL_UNSIGNED_EN
  task automatic test_unsigned();
    int dc;
    logic bok, hok;
    logic [W-1:0] rh, rl;
    run_op(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 0, '0, '0, dc, bok, hok, rh, rl);
    checks++;
    if (dc !== 18 || bok !== 1'b1) begin
      failures++;
      $display("FAIL unsigned_latency: done at %0d busy_ok=%b, required 18 1", dc, bok);
    end
    checks++;
    if (rh !== 32'hFFFFFFFE || rl !== 32'h1) begin
      failures++;
      $display("FAIL unsigned_product: result %h_%h, required fffffffe_00000001", rh, rl);
    end
    run_op(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 0, '0, '0, dc, bok, hok, rh, rl);
    checks++;
    if (dc !== 17 || rh !== 32'h0 || rl !== 32'h1) begin
      failures++;
      $display("FAIL unsigned_off: cycle %0d result %h_%h, required 17 00000000_00000001", dc, rh, rl);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_signed();
    test_back_to_back();
    test_ignore_start();
    test_abort_reset();
`ifdef MUL_UNSIGNED_EN
    test_unsigned();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
